// File: rtl/nec_ir_pkg.sv
// Shared NEC IR definitions: frame timing, transmitter states and the remote's key scan codes.
// Scan codes are stored bit-reversed, the way the MSB-first receiver shift register sees them.
package nec_ir_pkg;

   localparam int NEC_TICK_CYCLES        = 1750;
   localparam int NEC_LEADER_MARK_TICKS  = 257;
   localparam int NEC_LEADER_SPACE_TICKS = 128;
   localparam int NEC_BIT_MARK_TICKS     = 16;
   localparam int NEC_ZERO_SPACE_TICKS   = 16;
   localparam int NEC_ONE_SPACE_TICKS    = 48;
   localparam int NEC_GAP_TICKS          = 1143;
   localparam int NEC_CARRIER_HALF       = 658;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_LEADER_MARK,
      TX_LEADER_SPACE,
      TX_BIT_MARK,
      TX_BIT_SPACE,
      TX_STOP_MARK,
      TX_GAP
   } tx_state_t;

   localparam logic [7:0] N0         = 8'h68;
   localparam logic [7:0] N1         = 8'h30;
   localparam logic [7:0] N2         = 8'h18;
   localparam logic [7:0] N3         = 8'h7A;
   localparam logic [7:0] N4         = 8'h10;
   localparam logic [7:0] N5         = 8'h38;
   localparam logic [7:0] N6         = 8'h5A;
   localparam logic [7:0] N7         = 8'h42;
   localparam logic [7:0] N8         = 8'h4A;
   localparam logic [7:0] N9         = 8'h52;
   localparam logic [7:0] CHANNEL_DN = 8'hA2;
   localparam logic [7:0] CHANNEL    = 8'h62;
   localparam logic [7:0] CHANNEL_UP = 8'hE2;
   localparam logic [7:0] PLAY       = 8'hC2;
   localparam logic [7:0] EQ         = 8'h90;

   function automatic logic [31:0] nec_frame(input logic [7:0] a, input logic [7:0] c);
      return {a, ~a, c, ~c};
   endfunction

endpackage

// File: rtl/ir_tick_gen.sv
// Prescaler plus tick counter: phaseDone is high in the last clk cycle of a target-tick phase.
// Both counters restart after phaseDone, so consecutive phases never accumulate drift.
module ir_tick_gen #(
   parameter int TICK_CYCLES = 1750
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic [10:0] target,
   output logic        phaseDone
);

   localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

   logic [PW-1:0] pre;
   logic [10:0]   phase;
   logic          tick;

   assign tick      = (pre == PW'(TICK_CYCLES - 1));
   assign phaseDone = tick && (phase == target - 11'd1);

   always_ff @(posedge clk) begin
      if (rst || clear || phaseDone) begin
         pre   <= '0;
         phase <= '0;
      end else if (tick) begin
         pre   <= '0;
         phase <= phase + 11'd1;
      end else begin
         pre   <= pre + PW'(1);
      end
   end

endmodule

// File: rtl/nec_ir_transmitter.sv
// NEC IR frame transmitter: leader, 32 data bits MSB first and a stop mark, followed by an idle gap.
// irOut is the envelope for loopback; irCarrier is the same envelope gated by a ~38 kHz square wave.
module nec_ir_transmitter
   import nec_ir_pkg::*;
#(
   parameter int TICK_CYCLES        = NEC_TICK_CYCLES,
   parameter int LEADER_MARK_TICKS  = NEC_LEADER_MARK_TICKS,
   parameter int LEADER_SPACE_TICKS = NEC_LEADER_SPACE_TICKS,
   parameter int BIT_MARK_TICKS     = NEC_BIT_MARK_TICKS,
   parameter int ZERO_SPACE_TICKS   = NEC_ZERO_SPACE_TICKS,
   parameter int ONE_SPACE_TICKS    = NEC_ONE_SPACE_TICKS,
   parameter int GAP_TICKS          = NEC_GAP_TICKS,
   parameter int CARRIER_HALF       = NEC_CARRIER_HALF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] addr,
   input  logic [7:0] cmd,
   output logic       busy,
   output logic       done,
   output logic       irOut,
   output logic       irCarrier
);

   localparam int CW = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;

   tx_state_t     state;
   logic [31:0]   shreg;
   logic [5:0]    bitCount;
   logic [10:0]   target;
   logic          phaseDone;
   logic          tickClear;
   logic          markEntry;
   logic          markExit;
   logic          carrier;
   logic [CW-1:0] carCnt;
   logic          carWrap;

   always_comb begin
      target = 11'd1;
      case (state)
         TX_LEADER_MARK:  target = 11'(LEADER_MARK_TICKS);
         TX_LEADER_SPACE: target = 11'(LEADER_SPACE_TICKS);
         TX_BIT_MARK:     target = 11'(BIT_MARK_TICKS);
         TX_BIT_SPACE:    target = shreg[31] ? 11'(ONE_SPACE_TICKS) : 11'(ZERO_SPACE_TICKS);
         TX_STOP_MARK:    target = 11'(BIT_MARK_TICKS);
         TX_GAP:          target = 11'(GAP_TICKS);
         default:         target = 11'd1;
      endcase
   end

   // Counters sit at zero while idle, so the leader starts timing from the acceptance edge.
   assign tickClear = (state == TX_IDLE);

   ir_tick_gen #(
      .TICK_CYCLES (TICK_CYCLES)
   ) u_tick (
      .clk       (clk),
      .rst       (rst),
      .clear     (tickClear),
      .target    (target),
      .phaseDone (phaseDone)
   );

   assign markEntry = ((state == TX_IDLE) && start) ||
                      (phaseDone && ((state == TX_LEADER_SPACE) || (state == TX_BIT_SPACE)));
   assign markExit  = phaseDone && ((state == TX_LEADER_MARK) || (state == TX_BIT_MARK) ||
                                    (state == TX_STOP_MARK));

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= TX_IDLE;
         shreg    <= '0;
         bitCount <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         irOut    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            TX_IDLE: if (start) begin
               shreg <= {addr, ~addr, cmd, ~cmd};
               state <= TX_LEADER_MARK;
               busy  <= 1'b1;
               irOut <= 1'b1;
            end
            TX_LEADER_MARK: if (phaseDone) begin
               state <= TX_LEADER_SPACE;
               irOut <= 1'b0;
            end
            TX_LEADER_SPACE: if (phaseDone) begin
               state    <= TX_BIT_MARK;
               bitCount <= '0;
               irOut    <= 1'b1;
            end
            TX_BIT_MARK: if (phaseDone) begin
               state <= TX_BIT_SPACE;
               irOut <= 1'b0;
            end
            TX_BIT_SPACE: if (phaseDone) begin
               shreg    <= {shreg[30:0], 1'b0};
               bitCount <= bitCount + 6'd1;
               state    <= (bitCount == 6'd31) ? TX_STOP_MARK : TX_BIT_MARK;
               irOut    <= 1'b1;
            end
            TX_STOP_MARK: if (phaseDone) begin
               state <= TX_GAP;
               irOut <= 1'b0;
            end
            TX_GAP: if (phaseDone) begin
               state <= TX_IDLE;
               busy  <= 1'b0;
               done  <= 1'b1;
            end
            default: begin
               state <= TX_IDLE;
               busy  <= 1'b0;
               irOut <= 1'b0;
            end
         endcase
      end
   end

   assign carWrap = (carCnt == CW'(CARRIER_HALF - 1));

   // Carrier restarts high on each mark entry so every burst begins with a full half-period.
   always_ff @(posedge clk) begin
      if (rst || markEntry) begin
         carCnt  <= '0;
         carrier <= 1'b1;
      end else if (carWrap) begin
         carCnt  <= '0;
         carrier <= ~carrier;
      end else begin
         carCnt  <= carCnt + CW'(1);
      end

      if (rst) begin
         irCarrier <= 1'b0;
      end else if (markEntry) begin
         irCarrier <= 1'b1;
      end else if (markExit || !irOut) begin
         irCarrier <= 1'b0;
      end else begin
         irCarrier <= carWrap ? ~carrier : carrier;
      end
   end

endmodule

// File: tb/tb_nec_ir_transmitter.sv
// Bench for nec_ir_transmitter with shortened timing: a segment-level frame model predicts every
// output on every cycle, and a few literal measurements pin lengths, gaps and carrier phase.
module tb_nec_ir_transmitter;

   localparam int TK = 4;
   localparam int LM = 9;
   localparam int LS = 5;
   localparam int BM = 2;
   localparam int ZS = 2;
   localparam int OS = 5;
   localparam int GP = 7;
   localparam int CH = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] addr;
   logic [7:0] cmd;
   logic       busy;
   logic       done;
   logic       irOut;
   logic       irCarrier;

   int tests = 0;
   int fails = 0;
   int doneCnt = 0;
   int busyCnt = 0;

   typedef struct packed {
      logic ir;
      logic car;
      logic bsy;
      logic dn;
   } exp_t;

   exp_t q[$];

   nec_ir_transmitter #(
      .TICK_CYCLES        (TK),
      .LEADER_MARK_TICKS  (LM),
      .LEADER_SPACE_TICKS (LS),
      .BIT_MARK_TICKS     (BM),
      .ZERO_SPACE_TICKS   (ZS),
      .ONE_SPACE_TICKS    (OS),
      .GAP_TICKS          (GP),
      .CARRIER_HALF       (CH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .addr      (addr),
      .cmd       (cmd),
      .busy      (busy),
      .done      (done),
      .irOut     (irOut),
      .irCarrier (irCarrier)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] frame_word(input logic [7:0] a, input logic [7:0] c);
      logic [31:0] f;
      f[31:24] = a;
      f[23:16] = 8'hFF ^ a;
      f[15:8]  = c;
      f[7:0]   = 8'hFF ^ c;
      return f;
   endfunction

   // One level held for a number of ticks; marks carry a carrier that is high in even half-periods.
   function automatic void seg(input logic mk, input int ticks);
      for (int j = 0; j < ticks * TK; j++) begin
         q.push_back(exp_t'{mk, mk && (((j / CH) % 2) == 0), 1'b1, 1'b0});
      end
   endfunction

   function automatic void build(input logic [7:0] a, input logic [7:0] c);
      logic [31:0] f;
      f = frame_word(a, c);
      seg(1'b1, LM);
      seg(1'b0, LS);
      for (int i = 31; i >= 0; i--) begin
         seg(1'b1, BM);
         seg(1'b0, f[i] ? OS : ZS);
      end
      seg(1'b1, BM);
      seg(1'b0, GP);
      q.push_back(exp_t'{1'b0, 1'b0, 1'b0, 1'b1});
   endfunction

   // Compare process: check outputs of the last edge, then predict the next edge from current inputs.
   initial begin
      exp_t e;
      e = '0;
      forever begin
         @(negedge clk);
         chk("irOut", {31'd0, irOut}, {31'd0, e.ir});
         chk("irCarrier", {31'd0, irCarrier}, {31'd0, e.car});
         chk("busy", {31'd0, busy}, {31'd0, e.bsy});
         chk("done", {31'd0, done}, {31'd0, e.dn});
         if (done === 1'b1) doneCnt++;
         if (busy === 1'b1) busyCnt++;
         if (rst) begin
            q.delete();
            e = '0;
         end else if (q.size() != 0) begin
            e = q.pop_front();
         end else if (start) begin
            build(addr, cmd);
            e = q.pop_front();
         end else begin
            e = '0;
         end
      end
   end

   task automatic send(input logic [7:0] a, input logic [7:0] c);
      @(posedge clk); #1;
      addr  = a;
      cmd   = c;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic pulse_rst();
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n;
      n = 0;
      while (1) begin
         @(negedge clk);
         if (done === 1'b1) return;
         n++;
         if (n >= budget) begin
            chk("done_timeout", {31'd0, done}, 32'd1);
            return;
         end
      end
   endtask

   // Counts irOut rising edges from a frame that has just been accepted.
   task automatic wait_rises(input int k);
      int r;
      logic p;
      r = 0;
      p = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         if (irOut && !p) r++;
         p = irOut;
         if (r == k) return;
      end
      chk("rise_timeout", r, k);
   endtask

   // Length of the current run of lvl, counting the sample already seen.
   task automatic run_len(input logic lvl, output int n);
      n = 1;
      while (n < 5000) begin
         @(negedge clk);
         if (irOut !== lvl) break;
         n++;
      end
   endtask

   initial begin
      int n;
      int d0;
      int b0;
      rst   = 1'b1;
      start = 1'b0;
      addr  = 8'h00;
      cmd   = 8'h00;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_irOut", {31'd0, irOut}, 32'd0);
      chk("reset_irCarrier", {31'd0, irCarrier}, 32'd0);
      chk("reset_done", {31'd0, done}, 32'd0);

      chk("frame_word", frame_word(8'h00, 8'h30), 32'h00FF30CF);

      // Known frame 0x00FF30CF: leader lengths, busy span and one done pulse.
      d0 = doneCnt;
      b0 = busyCnt;
      send(8'h00, 8'h30);
      @(negedge clk);
      run_len(1'b1, n);
      chk("leader_mark_cycles", n, LM * TK);
      run_len(1'b0, n);
      chk("leader_space_cycles", n, LS * TK);
      wait_done(3000);
      chk("busy_cycles", busyCnt - b0, 796);
      chk("done_pulses_t1", doneCnt - d0, 1);

      // Boundary and random address/command pairs.
      send(8'hFF, 8'hFF);
      wait_done(3000);
      send(8'h00, 8'h00);
      wait_done(3000);
      for (int i = 0; i < 5; i++) begin
         send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
         repeat ($urandom_range(0, 5)) @(posedge clk);
         wait_done(3000);
      end

      // A second start during bit 10 must be ignored.
      d0 = doneCnt;
      send(8'h5A, 8'h68);
      wait_rises(12);
      send(8'hC3, 8'h52);
      wait_done(3000);
      repeat (10) @(negedge clk);
      chk("ignored_start_done", doneCnt - d0, 1);
      chk("ignored_start_busy", {31'd0, busy}, 32'd0);

      // Reset in the leader space and again during bit 20, each followed by a complete frame.
      d0 = doneCnt;
      send(8'h12, 8'h30);
      repeat (40) @(negedge clk);
      pulse_rst();
      @(negedge clk);
      chk("rst_ls_irOut", {31'd0, irOut}, 32'd0);
      chk("rst_ls_busy", {31'd0, busy}, 32'd0);
      send(8'h34, 8'h68);
      wait_done(3000);
      send(8'hA5, 8'h3C);
      wait_rises(22);
      pulse_rst();
      @(negedge clk);
      chk("rst_b20_irOut", {31'd0, irOut}, 32'd0);
      chk("rst_b20_irCarrier", {31'd0, irCarrier}, 32'd0);
      chk("rst_b20_busy", {31'd0, busy}, 32'd0);
      chk("rst_b20_done", {31'd0, done}, 32'd0);
      send(8'h9C, 8'h52);
      wait_done(3000);
      chk("rst_done_pulses", doneCnt - d0, 2);

      // start held high: back-to-back frames with a single idle cycle after done.
      d0 = doneCnt;
      @(posedge clk); #1;
      addr  = 8'($urandom_range(0, 255));
      cmd   = 8'($urandom_range(0, 255));
      start = 1'b1;
      wait_done(3000);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!irOut && n < 100);
      chk("held_start_idle", n, 1);
      repeat (50) @(negedge clk);
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(3000);
      chk("held_start_done", doneCnt - d0, 2);

      // Carrier phase at the start of the leader mark, then a quiet leader space.
      send(8'h12, 8'h34);
      @(negedge clk);
      chk("car_j0", {31'd0, irCarrier}, 32'd1);
      repeat (2) @(negedge clk);
      chk("car_j2", {31'd0, irCarrier}, 32'd1);
      @(negedge clk);
      chk("car_j3", {31'd0, irCarrier}, 32'd0);
      repeat (3) @(negedge clk);
      chk("car_j6", {31'd0, irCarrier}, 32'd1);
      repeat (34) @(negedge clk);
      chk("car_space", {31'd0, irCarrier}, 32'd0);
      chk("car_space_ir", {31'd0, irOut}, 32'd0);
      wait_done(3000);

      repeat (5) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
